// File: rtl/opl3_slot_scheduler.sv
// Sample-rate divider plus a (bank, operator) slot sequencer that walks every operator once per frame.
// Define OPL3_SCHED_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module opl3_slot_scheduler #(
    parameter int CLK_DIV_COUNT          = 256,
    parameter int NUM_BANKS              = 2,
    parameter int NUM_OPERATORS_PER_BANK = 18,
    parameter int SLOT_SPACING           = 4,
    parameter int BANK_NUM_WIDTH         = $clog2(NUM_BANKS),
    parameter int OP_NUM_WIDTH           = $clog2(NUM_OPERATORS_PER_BANK)
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      sample_clk_en,
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [BANK_NUM_WIDTH-1:0] bank_num,
    output logic [OP_NUM_WIDTH-1:0]   op_num,
    output logic                      frame_done,
    output logic                      overrun,
    input  logic                      overrun_clr
`ifdef OPL3_SCHED_OVERRUN_CNT_EN
    ,
    output logic [7:0]                overrun_cnt
`endif
);

    localparam int DIV_W = $clog2(CLK_DIV_COUNT);
    localparam int GAP_W = $clog2(SLOT_SPACING + 1);
    localparam logic [DIV_W-1:0]          DIV_LAST  = DIV_W'(CLK_DIV_COUNT - 1);
    localparam logic [BANK_NUM_WIDTH-1:0] BANK_LAST = BANK_NUM_WIDTH'(NUM_BANKS - 1);
    localparam logic [OP_NUM_WIDTH-1:0]   OP_LAST   = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);
    localparam logic [GAP_W-1:0]          GAP_LOAD  = GAP_W'(SLOT_SPACING - 1);

    if ((NUM_BANKS * NUM_OPERATORS_PER_BANK * SLOT_SPACING + 2 > CLK_DIV_COUNT) ||
        (SLOT_SPACING < 1)) begin : g_param_check
        $error("opl3_slot_scheduler: frame does not fit in CLK_DIV_COUNT or SLOT_SPACING < 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic                      sample_en_q, sample_en_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [BANK_NUM_WIDTH-1:0] bank_q, bank_d;
    logic [OP_NUM_WIDTH-1:0]   op_q, op_d;
    logic                      overrun_q, overrun_d;
    logic                      overrun_set;
    logic                      last_slot;

    // Divider free-runs; the tick flop is high during the cycle the count sits at its last value.
    always_comb begin
        div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        sample_en_d = (div_cnt_d == DIV_LAST);
    end

    assign last_slot   = (bank_q == BANK_LAST) && (op_q == OP_LAST);
    assign overrun_set = sample_en_q && (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        op_d      = op_q;
        gap_d     = gap_q;
        overrun_d = overrun_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
        case (state_q)
            IDLE: begin
                if (sample_en_q) begin
                    state_d = ISSUE;
                    bank_d  = '0;
                    op_d    = '0;
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    if (last_slot) begin
                        state_d = DONE;
                        bank_d  = '0;
                        op_d    = '0;
                    end else begin
                        if (op_q == OP_LAST) begin
                            op_d   = '0;
                            bank_d = bank_q + BANK_NUM_WIDTH'(1);
                        end else begin
                            op_d = op_q + OP_NUM_WIDTH'(1);
                        end
                        if (SLOT_SPACING > 1) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            GAP: begin
                // Leaving at 1 makes valid rises exactly SLOT_SPACING cycles apart.
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            sample_en_q <= 1'b0;
            gap_q       <= '0;
            bank_q      <= '0;
            op_q        <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            sample_en_q <= sample_en_d;
            gap_q       <= gap_d;
            bank_q      <= bank_d;
            op_q        <= op_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample_clk_en = sample_en_q;
    assign op_valid      = (state_q == ISSUE);
    assign frame_done    = (state_q == DONE);
    assign bank_num      = bank_q;
    assign op_num        = op_q;
    assign overrun       = overrun_q;

`ifdef OPL3_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q, overrun_cnt_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A dropped tick coinciding with a clear restarts the count at one.
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (overrun_set) begin
            overrun_cnt_d = overrun_clr ? 8'd1 : sat_inc8(overrun_cnt_q);
        end else if (overrun_clr) begin
            overrun_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt_q <= 8'd0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

endmodule
